// File: rtl/legv8_ctrl_pkg.sv
// Shared encodings for the LEGv8 multicycle control unit: sequencer states,
// ALU function selects, PC/data source selects, opcodes, condition codes and
// the bit offsets of each field inside the 96-bit control word.
package legv8_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_EXEC,
    ST_BRANCH,
    ST_HALTED
  } state_t;

  // ALU function selects
  localparam logic [4:0] FS_AND   = 5'b00000;
  localparam logic [4:0] FS_OR    = 5'b00100;
  localparam logic [4:0] FS_ADD   = 5'b01000;
  localparam logic [4:0] FS_SUB   = 5'b01001;
  localparam logic [4:0] FS_PASSA = 5'b11000;

  // Next-PC selects
  localparam logic [1:0] PS_HOLD = 2'b00;
  localparam logic [1:0] PS_INC  = 2'b01;
  localparam logic [1:0] PS_JUMP = 2'b10;
  localparam logic [1:0] PS_REL  = 2'b11;

  // Register-file write-data selects
  localparam logic [1:0] DS_ALU  = 2'b00;
  localparam logic [1:0] DS_REGB = 2'b01;
  localparam logic [1:0] DS_PC   = 2'b10;
  localparam logic [1:0] DS_MEM  = 2'b11;

  // R- and D-format opcodes occupy IR[31:21]
  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_ADDS = 11'b10101011000;
  localparam logic [10:0] OP_SUBS = 11'b11101011000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  // I-format opcodes use only IR[31:22]; the low opcode bit belongs to the immediate
  localparam logic [9:0]  OP_ADDI = 10'b1001000100;
  localparam logic [9:0]  OP_SUBI = 10'b1101000100;
  // B uses IR[31:26]; CB formats use IR[31:24]
  localparam logic [5:0]  OP_B     = 6'b000101;
  localparam logic [7:0]  OP_BCOND = 8'b01010100;
  localparam logic [7:0]  OP_CBZ   = 8'b10110100;

  // Condition codes in IR[3:0] of B.cond
  localparam logic [3:0] COND_EQ = 4'd0;
  localparam logic [3:0] COND_NE = 4'd1;
  localparam logic [3:0] COND_HS = 4'd2;
  localparam logic [3:0] COND_LO = 4'd3;
  localparam logic [3:0] COND_MI = 4'd4;
  localparam logic [3:0] COND_PL = 4'd5;
  localparam logic [3:0] COND_VS = 4'd6;
  localparam logic [3:0] COND_VC = 4'd7;
  localparam logic [3:0] COND_HI = 4'd8;
  localparam logic [3:0] COND_LS = 4'd9;
  localparam logic [3:0] COND_GE = 4'd10;
  localparam logic [3:0] COND_LT = 4'd11;
  localparam logic [3:0] COND_GT = 4'd12;
  localparam logic [3:0] COND_LE = 4'd13;
  localparam logic [3:0] COND_AL = 4'd14;

  // Low bit position of each control-word field (MSB-first layout)
  localparam int CW_WRITE      = 95;
  localparam int CW_AA         = 90;
  localparam int CW_BA         = 85;
  localparam int CW_DA         = 80;
  localparam int CW_K          = 16;
  localparam int CW_FS         = 11;
  localparam int CW_BSEL       = 10;
  localparam int CW_CIN        = 9;
  localparam int CW_LOADSTATUS = 8;
  localparam int CW_RAMWRITE   = 7;
  localparam int CW_PCSEL      = 6;
  localparam int CW_PS         = 4;
  localparam int CW_LOADIR     = 3;
  localparam int CW_AS         = 2;
  localparam int CW_DS         = 0;

endpackage

// File: rtl/legv8_control_unit_if.sv
// Bus between the control unit and the datapath. The datapath side (master)
// supplies start, the instruction register and flags; the control unit
// (slave) returns the control word and its status outputs.
interface legv8_control_unit_if;
  logic        start;
  logic [31:0] IR;
  logic [3:0]  status;
  logic [95:0] controlWord;
  logic        busy;
  logic        halted;
  logic        fault;
  logic [31:0] instret;

  modport master (
    output start, IR, status,
    input  controlWord, busy, halted, fault, instret
  );

  modport slave (
    input  start, IR, status,
    output controlWord, busy, halted, fault, instret
  );
endinterface

// File: rtl/legv8_cond_eval.sv
// Evaluates an ARM B.cond condition code against the {V,C,N,Z} flags.
module legv8_cond_eval
  import legv8_ctrl_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] status,
  output logic       taken
);

  logic flag_v, flag_c, flag_n, flag_z;
  assign {flag_v, flag_c, flag_n, flag_z} = status;

  // Condition lookup; code 15 falls into the default and is treated as always
  always_comb begin
    taken = 1'b1;
    case (cond)
      COND_EQ: taken = flag_z;
      COND_NE: taken = !flag_z;
      COND_HS: taken = flag_c;
      COND_LO: taken = !flag_c;
      COND_MI: taken = flag_n;
      COND_PL: taken = !flag_n;
      COND_VS: taken = flag_v;
      COND_VC: taken = !flag_v;
      COND_HI: taken = flag_c && !flag_z;
      COND_LS: taken = !(flag_c && !flag_z);
      COND_GE: taken = (flag_n == flag_v);
      COND_LT: taken = (flag_n != flag_v);
      COND_GT: taken = !flag_z && (flag_n == flag_v);
      COND_LE: taken = !(!flag_z && (flag_n == flag_v));
      COND_AL: taken = 1'b1;
      default: taken = 1'b1;
    endcase
  end

endmodule

// File: rtl/legv8_control_unit.sv
// Multicycle sequencer for the LEGv8 datapath. Steps FETCH -> EXEC (-> BRANCH
// for CBZ), decodes IR into the 96-bit control word, counts retired
// instructions and latches a sticky fault on undecodable instructions.
module legv8_control_unit
  import legv8_ctrl_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset,
  legv8_control_unit_if.slave  bus
);

  state_t      state;
  logic        busy_q, halted_q, fault_q;
  logic [31:0] instret_q;

  logic [95:0] exec_word, branch_word, cw;
  logic        exec_legal, exec_cbz, cond_taken;
  logic [10:0] op11;
  logic [63:0] k_imm, k_mem, k_b, k_cb;

  assign op11  = bus.IR[31:21];
  assign k_imm = {52'd0, bus.IR[21:10]};
  assign k_mem = {{55{bus.IR[20]}}, bus.IR[20:12]};
  assign k_b   = {{36{bus.IR[25]}}, bus.IR[25:0], 2'b00};
  assign k_cb  = {{43{bus.IR[23]}}, bus.IR[23:5], 2'b00};

  legv8_cond_eval u_cond_eval (
    .cond   (bus.IR[3:0]),
    .status (bus.status),
    .taken  (cond_taken)
  );

  // Decode the EXEC control word; HALT and unknown encodings give an all-zero word
  always_comb begin
    exec_word = '0;
    exec_word[CW_PS +: 2] = PS_INC;
    exec_legal = 1'b1;
    exec_cbz   = 1'b0;
    if (bus.IR == 32'd0) begin
      exec_word  = '0;
      exec_legal = 1'b0;
    end else if (op11 inside {OP_ADD, OP_SUB, OP_AND, OP_ORR, OP_ADDS, OP_SUBS}) begin
      exec_word[CW_WRITE]    = 1'b1;
      exec_word[CW_AA +: 5]  = bus.IR[9:5];
      exec_word[CW_BA +: 5]  = bus.IR[20:16];
      exec_word[CW_DA +: 5]  = bus.IR[4:0];
      exec_word[CW_DS +: 2]  = DS_ALU;
      case (op11)
        OP_SUB, OP_SUBS: begin
          exec_word[CW_FS +: 5] = FS_SUB;
          exec_word[CW_CIN]     = 1'b1;
        end
        OP_AND:  exec_word[CW_FS +: 5] = FS_AND;
        OP_ORR:  exec_word[CW_FS +: 5] = FS_OR;
        default: exec_word[CW_FS +: 5] = FS_ADD;
      endcase
      exec_word[CW_LOADSTATUS] = (op11 == OP_ADDS) || (op11 == OP_SUBS);
    end else if (bus.IR[31:22] == OP_ADDI || bus.IR[31:22] == OP_SUBI) begin
      exec_word[CW_WRITE]    = 1'b1;
      exec_word[CW_AA +: 5]  = bus.IR[9:5];
      exec_word[CW_BA +: 5]  = bus.IR[20:16];
      exec_word[CW_DA +: 5]  = bus.IR[4:0];
      exec_word[CW_K +: 64]  = k_imm;
      exec_word[CW_BSEL]     = 1'b1;
      exec_word[CW_FS +: 5]  = (bus.IR[31:22] == OP_SUBI) ? FS_SUB : FS_ADD;
      exec_word[CW_CIN]      = (bus.IR[31:22] == OP_SUBI);
    end else if (op11 == OP_LDUR) begin
      exec_word[CW_WRITE]    = 1'b1;
      exec_word[CW_AA +: 5]  = bus.IR[9:5];
      exec_word[CW_DA +: 5]  = bus.IR[4:0];
      exec_word[CW_K +: 64]  = k_mem;
      exec_word[CW_BSEL]     = 1'b1;
      exec_word[CW_FS +: 5]  = FS_ADD;
      exec_word[CW_DS +: 2]  = DS_MEM;
    end else if (op11 == OP_STUR) begin
      exec_word[CW_AA +: 5]  = bus.IR[9:5];
      exec_word[CW_BA +: 5]  = bus.IR[4:0];
      exec_word[CW_K +: 64]  = k_mem;
      exec_word[CW_BSEL]     = 1'b1;
      exec_word[CW_FS +: 5]  = FS_ADD;
      exec_word[CW_DS +: 2]  = DS_REGB;
      exec_word[CW_RAMWRITE] = 1'b1;
    end else if (bus.IR[31:26] == OP_B) begin
      exec_word[CW_K +: 64]  = k_b;
      exec_word[CW_PS +: 2]  = PS_REL;
    end else if (bus.IR[31:24] == OP_BCOND) begin
      exec_word[CW_K +: 64]  = k_cb;
      exec_word[CW_PS +: 2]  = cond_taken ? PS_REL : PS_INC;
    end else if (bus.IR[31:24] == OP_CBZ) begin
      exec_word[CW_AA +: 5]    = bus.IR[4:0];
      exec_word[CW_FS +: 5]    = FS_PASSA;
      exec_word[CW_LOADSTATUS] = 1'b1;
      exec_word[CW_PS +: 2]    = PS_HOLD;
      exec_cbz                 = 1'b1;
    end else begin
      exec_word  = '0;
      exec_legal = 1'b0;
    end
  end

  // CBZ resolve word: relative branch when the flags written in EXEC show zero
  always_comb begin
    branch_word = '0;
    branch_word[CW_K +: 64] = k_cb;
    branch_word[CW_PS +: 2] = bus.status[0] ? PS_REL : PS_INC;
  end

  // Select the word for the current state; IDLE and HALTED drive a safe NOP
  always_comb begin
    cw = '0;
    case (state)
      ST_FETCH: begin
        cw[CW_AS]       = 1'b1;
        cw[CW_LOADIR]   = 1'b1;
        cw[CW_PS +: 2]  = PS_HOLD;
      end
      ST_EXEC:   cw = exec_word;
      ST_BRANCH: cw = branch_word;
      default:   cw = '0;
    endcase
  end

  // Sequencer with registered status outputs and retired-instruction counter
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      busy_q    <= 1'b0;
      halted_q  <= 1'b0;
      fault_q   <= 1'b0;
      instret_q <= 32'd0;
    end else begin
      case (state)
        ST_IDLE, ST_HALTED: begin
          if (bus.start) begin
            state    <= ST_FETCH;
            busy_q   <= 1'b1;
            halted_q <= 1'b0;
          end
        end
        ST_FETCH: state <= ST_EXEC;
        ST_EXEC: begin
          if (!exec_legal) begin
            state    <= ST_HALTED;
            busy_q   <= 1'b0;
            halted_q <= 1'b1;
            if (bus.IR != 32'd0) fault_q <= 1'b1;
          end else begin
            state     <= exec_cbz ? ST_BRANCH : ST_FETCH;
            instret_q <= instret_q + 32'd1;
          end
        end
        ST_BRANCH: state <= ST_FETCH;
        default: begin
          state    <= ST_IDLE;
          busy_q   <= 1'b0;
          halted_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.controlWord = cw;
  assign bus.busy        = busy_q;
  assign bus.halted      = halted_q;
  assign bus.fault       = fault_q;
  assign bus.instret     = instret_q;

endmodule

// File: tb/tb_legv8_control_unit.sv
// Directed-vector bench for legv8_control_unit: walks a short program through
// the sequencer and compares control words and status outputs with
// hand-computed values.
module tb_legv8_control_unit;
  import legv8_ctrl_pkg::*;

  logic clock = 1'b0;
  logic reset;
  int   check_count = 0;
  int   error_count = 0;
  logic [31:0] exp_instret;

  legv8_control_unit_if bus ();

  legv8_control_unit dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // Builds a control word from its fields in the documented MSB-first order
  function automatic logic [95:0] mk(
    input logic wr, input logic [4:0] aa, input logic [4:0] ba, input logic [4:0] da,
    input logic [63:0] k, input logic [4:0] fs, input logic bsel, input logic cin,
    input logic ls, input logic rw, input logic [1:0] ps, input logic lir,
    input logic as_sel, input logic [1:0] ds);
    return {wr, aa, ba, da, k, fs, bsel, cin, ls, rw, 1'b0, ps, lir, as_sel, ds};
  endfunction

  localparam logic [95:0] FETCH_W = 96'h0000_0000_0000_0000_0000_000C;

  task automatic checkOutput(input string tag, input logic [95:0] observed,
                             input logic [95:0] expected);
    check_count++;
    if (observed !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Loads IR/status at the FETCH falling edge, then moves into EXEC
  task automatic applyStimulus(input logic [31:0] ir, input logic [3:0] st);
    @(negedge clock);
    bus.IR     = ir;
    bus.status = st;
    @(posedge clock);
    #1;
  endtask

  task automatic pulseStart();
    @(negedge clock);
    bus.start = 1'b1;
    @(posedge clock);
    #1;
    bus.start = 1'b0;
  endtask

  // Runs a two-cycle instruction and checks its EXEC word and the retire count
  task automatic runSimple(input string tag, input logic [31:0] ir, input logic [3:0] st,
                           input logic [95:0] exp_word);
    applyStimulus(ir, st);
    checkOutput({tag, "_cw"}, bus.controlWord, exp_word);
    step();
    exp_instret = exp_instret + 32'd1;
    checkOutput({tag, "_instret"}, bus.instret, exp_instret);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL timeout: observed running expected finished");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    bus.start  = 1'b0;
    bus.IR     = 32'd0;
    bus.status = 4'd0;
    reset      = 1'b0;
    exp_instret = 32'd0;
    repeat (2) @(posedge clock);
    #1;
    checkOutput("reset_cw", bus.controlWord, '0);
    checkOutput("reset_busy", bus.busy, 0);
    checkOutput("reset_halted", bus.halted, 0);
    checkOutput("reset_fault", bus.fault, 0);
    checkOutput("reset_instret", bus.instret, 0);
    @(negedge clock);
    reset = 1'b1;

    pulseStart();
    checkOutput("fetch_cw", bus.controlWord, FETCH_W);
    checkOutput("fetch_busy", bus.busy, 1);

    applyStimulus(32'h8B020023, 4'h0);
    checkOutput("add_cw", bus.controlWord,
                mk(1, 5'd1, 5'd2, 5'd3, 64'd0, FS_ADD, 0, 0, 0, 0, 2'b01, 0, 0, 2'b00));
    checkOutput("add_instret_pre", bus.instret, 0);
    step();
    exp_instret = 32'd1;
    checkOutput("add_instret", bus.instret, exp_instret);
    checkOutput("refetch_cw", bus.controlWord, FETCH_W);

    runSimple("subi", 32'hD10010A5, 4'h0,
              mk(1, 5'd5, 5'd0, 5'd5, 64'd4, FS_SUB, 1, 1, 0, 0, 2'b01, 0, 0, 2'b00));
    runSimple("beq_taken", 32'h54000060, 4'b0001,
              mk(0, 5'd0, 5'd0, 5'd0, 64'd12, 5'd0, 0, 0, 0, 0, 2'b11, 0, 0, 2'b00));
    runSimple("beq_not", 32'h54000060, 4'b0000,
              mk(0, 5'd0, 5'd0, 5'd0, 64'd12, 5'd0, 0, 0, 0, 0, 2'b01, 0, 0, 2'b00));
    runSimple("bgt_taken", 32'h5400006C, 4'b1010,
              mk(0, 5'd0, 5'd0, 5'd0, 64'd12, 5'd0, 0, 0, 0, 0, 2'b11, 0, 0, 2'b00));
    runSimple("blt_not", 32'h5400006B, 4'b1010,
              mk(0, 5'd0, 5'd0, 5'd0, 64'd12, 5'd0, 0, 0, 0, 0, 2'b01, 0, 0, 2'b00));
    runSimple("b_back", 32'h17FFFFFF, 4'h0,
              mk(0, 5'd0, 5'd0, 5'd0, 64'hFFFF_FFFF_FFFF_FFFC, 5'd0, 0, 0, 0, 0, 2'b11, 0, 0, 2'b00));

    applyStimulus(32'hB4000107, 4'b0001);
    checkOutput("cbz_exec_cw", bus.controlWord,
                mk(0, 5'd7, 5'd0, 5'd0, 64'd0, FS_PASSA, 0, 0, 1, 0, 2'b00, 0, 0, 2'b00));
    step();
    exp_instret = exp_instret + 32'd1;
    checkOutput("cbz_branch_cw", bus.controlWord,
                mk(0, 5'd0, 5'd0, 5'd0, 64'd32, 5'd0, 0, 0, 0, 0, 2'b11, 0, 0, 2'b00));
    checkOutput("cbz_branch_busy", bus.busy, 1);
    checkOutput("cbz_instret", bus.instret, exp_instret);
    step();
    checkOutput("cbz_refetch_cw", bus.controlWord, FETCH_W);
    checkOutput("cbz_instret_once", bus.instret, exp_instret);

    applyStimulus(32'hB4000107, 4'b0000);
    step();
    exp_instret = exp_instret + 32'd1;
    checkOutput("cbz_nz_branch_cw", bus.controlWord,
                mk(0, 5'd0, 5'd0, 5'd0, 64'd32, 5'd0, 0, 0, 0, 0, 2'b01, 0, 0, 2'b00));
    step();

    runSimple("stur", 32'hF81F8082, 4'h0,
              mk(0, 5'd4, 5'd2, 5'd0, 64'hFFFF_FFFF_FFFF_FFF8, FS_ADD, 1, 0, 0, 1, 2'b01, 0, 0, 2'b01));
    runSimple("ldur", 32'hF8410029, 4'h0,
              mk(1, 5'd1, 5'd0, 5'd9, 64'd16, FS_ADD, 1, 0, 0, 0, 2'b01, 0, 0, 2'b11));
    runSimple("adds", 32'hAB020020, 4'h0,
              mk(1, 5'd1, 5'd2, 5'd0, 64'd0, FS_ADD, 0, 0, 1, 0, 2'b01, 0, 0, 2'b00));

    applyStimulus(32'h0000_0000, 4'h0);
    checkOutput("halt_cw", bus.controlWord, '0);
    step();
    checkOutput("halt_halted", bus.halted, 1);
    checkOutput("halt_busy", bus.busy, 0);
    checkOutput("halt_instret", bus.instret, exp_instret);
    checkOutput("halt_fault", bus.fault, 0);

    pulseStart();
    checkOutput("restart_cw", bus.controlWord, FETCH_W);
    checkOutput("restart_halted", bus.halted, 0);

    applyStimulus(32'hFFFF_FFFF, 4'h0);
    checkOutput("bad_cw", bus.controlWord, '0);
    step();
    checkOutput("bad_fault", bus.fault, 1);
    checkOutput("bad_halted", bus.halted, 1);
    checkOutput("bad_instret", bus.instret, exp_instret);

    pulseStart();
    checkOutput("refault_cw", bus.controlWord, FETCH_W);
    checkOutput("refault_sticky", bus.fault, 1);

    applyStimulus(32'h8B020023, 4'h0);
    @(negedge clock);
    reset = 1'b0;
    #1;
    checkOutput("midreset_cw", bus.controlWord, '0);
    checkOutput("midreset_busy", bus.busy, 0);
    checkOutput("midreset_fault", bus.fault, 0);
    checkOutput("midreset_instret", bus.instret, 0);
    step();
    checkOutput("midreset_hold_cw", bus.controlWord, '0);
    checkOutput("midreset_hold_instret", bus.instret, 0);

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule
